// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver state encoding and the
// 3-sample majority vote used for bit decisions.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE_LOCK  = 3'd0,
    S_HUNT       = 3'd1,
    S_START      = 3'd2,
    S_DATA       = 3'd3,
    S_PARITY     = 3'd4,
    S_STOP       = 3'd5,
    S_BREAK_WAIT = 3'd6
  } rx_state_t;

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick generator: free-running BAUD_DIV divider with a synchronous
// clear so a frame can be phase-aligned to its start edge.
module uart_os_tick #(
  parameter int BAUD_DIV = 313
) (
  input  logic clk,
  input  logic res,
  input  logic clr,
  output logic tick
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cnt <= '0;
    end else if (clr || cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = !clr && (cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with 3-sample majority vote, optional parity,
// framing-error detection and an idle-line lock before the first frame.
//
// state        | meaning
// S_IDLE_LOCK  | after reset, wait for IDLE_BITS consecutive high bit-times
// S_HUNT       | wait for a falling edge on the synchronised line
// S_START      | validate start bit by majority; a high majority is a glitch
// S_DATA       | shift in DATA_BITS bits, LSB first
// S_PARITY     | sample the parity bit
// S_STOP       | sample stop bit, commit word and flags at the 3rd sample
// S_BREAK_WAIT | line held low after a bad stop bit; wait for it to go high
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = 313,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int IDLE_BITS  = 12
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int IW = $clog2(IDLE_BITS + 1);

  localparam logic [SW-1:0] SUB_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SAMP_1ST  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SAMP_MID  = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_BITS - 1);

  rx_state_t state, state_nxt;

  logic                 rx_m, rx_s, rx_prev;
  logic                 tick;
  logic [SW-1:0]        sub_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [IW-1:0]        idle_cnt;
  logic [1:0]           samp;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bit;

  logic start_edge, s_first, s_mid, s_last, bit_end, maj, par_x, perr_nxt;

  assign start_edge = (state == S_HUNT) && rx_prev && !rx_s;
  assign s_first    = tick && (sub_cnt == SAMP_1ST);
  assign s_mid      = tick && (sub_cnt == SAMP_MID);
  assign s_last     = tick && (sub_cnt == SAMP_LAST);
  assign bit_end    = tick && (sub_cnt == SUB_LAST);
  // Third sample is the live line value, so the vote is ready on that tick.
  assign maj        = majority3({rx_s, samp});
  assign par_x      = (^shift_reg) ^ par_bit;
  assign perr_nxt   = (PARITY == PARITY_ODD)  ? !par_x :
                      (PARITY == PARITY_EVEN) ?  par_x : 1'b0;

  uart_os_tick #(.BAUD_DIV(BAUD_DIV)) u_tick (
    .clk  (clk),
    .res  (res),
    .clr  (start_edge),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state <= S_IDLE_LOCK;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE_LOCK:  if (rx_s && bit_end && idle_cnt == IDLE_LAST) state_nxt = S_HUNT;
      S_HUNT:       if (start_edge) state_nxt = S_START;
      S_START: begin
        if (s_last && maj)  state_nxt = S_HUNT;
        else if (bit_end)   state_nxt = S_DATA;
      end
      S_DATA: begin
        if (bit_end && bit_cnt == BIT_LAST)
          state_nxt = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
      end
      S_PARITY:     if (bit_end) state_nxt = S_STOP;
      S_STOP:       if (s_last) state_nxt = maj ? S_HUNT : S_BREAK_WAIT;
      S_BREAK_WAIT: if (rx_s) state_nxt = S_HUNT;
      default:      state_nxt = S_IDLE_LOCK;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      rx_prev    <= 1'b1;
      sub_cnt    <= '0;
      bit_cnt    <= '0;
      idle_cnt   <= '0;
      samp       <= '0;
      shift_reg  <= '0;
      par_bit    <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rx_m       <= rx;
      rx_s       <= rx_m;
      rx_prev    <= rx_s;
      data_valid <= 1'b0;

      if (start_edge || (state == S_IDLE_LOCK && !rx_s)) begin
        sub_cnt <= '0;
      end else if (tick) begin
        sub_cnt <= (sub_cnt == SUB_LAST) ? '0 : sub_cnt + 1'b1;
      end

      if (state == S_IDLE_LOCK) begin
        if (!rx_s)        idle_cnt <= '0;
        else if (bit_end) idle_cnt <= idle_cnt + 1'b1;
      end

      if (s_first) samp[0] <= rx_s;
      if (s_mid)   samp[1] <= rx_s;

      case (state)
        S_START: begin
          if (s_last && !maj) busy <= 1'b1;
          if (bit_end)        bit_cnt <= '0;
        end
        S_DATA: begin
          if (s_last)  shift_reg <= {maj, shift_reg[DATA_BITS-1:1]};
          if (bit_end) bit_cnt <= bit_cnt + 1'b1;
        end
        S_PARITY: begin
          if (s_last) par_bit <= maj;
        end
        S_STOP: begin
          if (s_last) begin
            data_out   <= shift_reg;
            parity_err <= perr_nxt;
            frame_err  <= !maj;
            data_valid <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: an 8N1 instance and an odd-parity instance
// share one stimulus line selected by sel.
module tb_uart_rx_os;

  localparam int BCLK = 64;

  logic clk = 1'b0;
  logic res;
  logic rx_line;
  logic sel;
  logic rx0, rx1;

  logic [7:0] dout0, dout1;
  logic dv0, pe0, fe0, busy0;
  logic dv1, pe1, fe1, busy1;

  int checks = 0;
  int passed = 0;

  int nv0 = 0, nv1 = 0;
  logic [7:0] cap0 = '0, cap1 = '0;
  logic cpe0 = 0, cfe0 = 0, cpe1 = 0, cfe1 = 0;
  bit busy_seen0 = 0;

  assign rx0 = sel ? 1'b1 : rx_line;
  assign rx1 = sel ? rx_line : 1'b1;

  always #5 clk = ~clk;

  uart_rx_os #(.BAUD_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .IDLE_BITS(12)) dut0 (
    .clk(clk), .res(res), .rx(rx0), .data_out(dout0), .data_valid(dv0),
    .parity_err(pe0), .frame_err(fe0), .busy(busy0));

  uart_rx_os #(.BAUD_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(1), .IDLE_BITS(12)) dut1 (
    .clk(clk), .res(res), .rx(rx1), .data_out(dout1), .data_valid(dv1),
    .parity_err(pe1), .frame_err(fe1), .busy(busy1));

  always @(negedge clk) begin
    if (dv0) begin nv0++; cap0 = dout0; cpe0 = pe0; cfe0 = fe0; end
    if (dv1) begin nv1++; cap1 = dout1; cpe1 = pe1; cfe1 = fe1; end
    if (busy0) busy_seen0 = 1;
  end

  task automatic drive_bit(input logic v, input int n);
    rx_line = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int bits);
    drive_bit(1'b1, bits * BCLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit use_par, input logic pbit,
                            input logic stop, input int bclk);
    drive_bit(1'b0, bclk);
    for (int i = 0; i < 8; i++) drive_bit(d[i], bclk);
    if (use_par) drive_bit(pbit, bclk);
    drive_bit(stop, bclk);
  endtask

  task automatic test_reset();
    res = 1'b1; rx_line = 1'b1; sel = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({dout0, dv0, pe0, fe0, busy0} !== 12'h000 || {dout1, dv1, pe1, fe1, busy1} !== 12'h000)
      $display("FAIL reset_outputs: got %h/%h want 000/000",
               {dout0, dv0, pe0, fe0, busy0}, {dout1, dv1, pe1, fe1, busy1});
    else passed++;
    res = 1'b0;
    idle(13);
  endtask

  task automatic test_basic();
    int n;
    n = nv0;
    send_frame(8'hAA, 0, 1'b0, 1'b1, BCLK);
    repeat (2) @(negedge clk);
    checks++; if (nv0 !== n + 1) $display("FAIL aa_count: got %0d want %0d", nv0, n + 1); else passed++;
    checks++; if (cap0 !== 8'hAA) $display("FAIL aa_data: got %h want aa", cap0); else passed++;
    checks++; if ({cpe0, cfe0} !== 2'b00) $display("FAIL aa_flags: got %b want 00", {cpe0, cfe0}); else passed++;
    send_frame(8'h55, 0, 1'b0, 1'b1, BCLK);
    repeat (2) @(negedge clk);
    checks++; if (nv0 !== n + 2) $display("FAIL b2b_count: got %0d want %0d", nv0, n + 2); else passed++;
    checks++; if (cap0 !== 8'h55) $display("FAIL b2b_data: got %h want 55", cap0); else passed++;
    checks++; if (dout0 !== 8'h55) $display("FAIL hold_data: got %h want 55", dout0); else passed++;
    idle(2);
  endtask

  task automatic test_idle_lock();
    int n;
    res = 1'b1; rx_line = 1'b1;
    repeat (3) @(negedge clk);
    res = 1'b0;
    n = nv0; busy_seen0 = 0;
    idle(5);
    send_frame(8'h00, 0, 1'b0, 1'b1, BCLK);
    repeat (2) @(negedge clk);
    checks++; if (nv0 !== n) $display("FAIL lock_no_valid: got %0d want %0d", nv0, n); else passed++;
    checks++; if (busy_seen0 !== 1'b0) $display("FAIL lock_no_busy: got %b want 0", busy_seen0); else passed++;
    idle(13);
    send_frame(8'h3C, 0, 1'b0, 1'b1, BCLK);
    repeat (2) @(negedge clk);
    checks++; if (nv0 !== n + 1) $display("FAIL lock_count: got %0d want %0d", nv0, n + 1); else passed++;
    checks++; if (cap0 !== 8'h3C) $display("FAIL lock_data: got %h want 3c", cap0); else passed++;
    idle(2);
  endtask

  // 0x07 has three ones: with odd parity, p=1 makes XOR(data,p)=0 -> error; p=0 -> clean.
  task automatic test_parity();
    int n, m;
    sel = 1'b1;
    idle(1);
    n = nv1; m = nv0;
    send_frame(8'h07, 1, 1'b1, 1'b1, BCLK);
    repeat (2) @(negedge clk);
    checks++; if (nv1 !== n + 1) $display("FAIL par_count: got %0d want %0d", nv1, n + 1); else passed++;
    checks++; if (cap1 !== 8'h07) $display("FAIL par_data: got %h want 07", cap1); else passed++;
    checks++; if (cpe1 !== 1'b1) $display("FAIL par_err_set: got %b want 1", cpe1); else passed++;
    checks++; if (pe1 !== 1'b1) $display("FAIL par_err_held: got %b want 1", pe1); else passed++;
    idle(1);
    send_frame(8'h07, 1, 1'b0, 1'b1, BCLK);
    repeat (2) @(negedge clk);
    checks++; if (nv1 !== n + 2) $display("FAIL par2_count: got %0d want %0d", nv1, n + 2); else passed++;
    checks++; if ({cpe1, cfe1} !== 2'b00) $display("FAIL par2_flags: got %b want 00", {cpe1, cfe1}); else passed++;
    checks++; if (nv0 !== m) $display("FAIL par_other_quiet: got %0d want %0d", nv0, m); else passed++;
    idle(1);
    sel = 1'b0;
    idle(1);
  endtask

  task automatic test_framing();
    int n;
    n = nv0;
    send_frame(8'h81, 0, 1'b0, 1'b0, BCLK);
    repeat (2) @(negedge clk);
    checks++; if (nv0 !== n + 1) $display("FAIL fe_count: got %0d want %0d", nv0, n + 1); else passed++;
    checks++; if (cap0 !== 8'h81) $display("FAIL fe_data: got %h want 81", cap0); else passed++;
    checks++; if (cfe0 !== 1'b1) $display("FAIL fe_flag: got %b want 1", cfe0); else passed++;
    drive_bit(1'b0, 20 * BCLK);
    checks++; if (nv0 !== n + 1) $display("FAIL break_quiet: got %0d want %0d", nv0, n + 1); else passed++;
    checks++; if (fe0 !== 1'b1) $display("FAIL fe_held: got %b want 1", fe0); else passed++;
    idle(2);
    send_frame(8'h42, 0, 1'b0, 1'b1, BCLK);
    repeat (2) @(negedge clk);
    checks++; if (cap0 !== 8'h42) $display("FAIL fe_recover_data: got %h want 42", cap0); else passed++;
    checks++; if ({cpe0, cfe0} !== 2'b00) $display("FAIL fe_recover_flags: got %b want 00", {cpe0, cfe0}); else passed++;
    idle(1);
  endtask

  task automatic test_glitch();
    int n;
    n = nv0; busy_seen0 = 0;
    drive_bit(1'b0, 12);
    idle(2);
    checks++; if (nv0 !== n) $display("FAIL glitch_valid: got %0d want %0d", nv0, n); else passed++;
    checks++; if (busy_seen0 !== 1'b0) $display("FAIL glitch_busy: got %b want 0", busy_seen0); else passed++;
    send_frame(8'hF0, 0, 1'b0, 1'b1, BCLK);
    repeat (2) @(negedge clk);
    checks++; if (nv0 !== n + 1) $display("FAIL glitch_next_count: got %0d want %0d", nv0, n + 1); else passed++;
    checks++; if (cap0 !== 8'hF0) $display("FAIL glitch_next_data: got %h want f0", cap0); else passed++;
    idle(1);
  endtask

  task automatic test_reset_mid_frame();
    int n;
    logic [7:0] d;
    d = 8'h99;
    n = nv0;
    drive_bit(1'b0, BCLK);
    for (int i = 0; i < 4; i++) drive_bit(d[i], BCLK);
    drive_bit(d[4], BCLK / 2);
    checks++; if (busy0 !== 1'b1) $display("FAIL midframe_busy: got %b want 1", busy0); else passed++;
    res = 1'b1;
    #1;
    checks++;
    if ({dout0, dv0, pe0, fe0, busy0} !== 12'h000)
      $display("FAIL async_reset: got %h want 000", {dout0, dv0, pe0, fe0, busy0});
    else passed++;
    repeat (3) @(negedge clk);
    res = 1'b0;
    idle(13);
    checks++; if (nv0 !== n) $display("FAIL reset_no_valid: got %0d want %0d", nv0, n); else passed++;
    send_frame(8'h99, 0, 1'b0, 1'b1, BCLK);
    repeat (2) @(negedge clk);
    checks++; if (cap0 !== 8'h99) $display("FAIL post_reset_data: got %h want 99", cap0); else passed++;
    idle(1);
  endtask

  task automatic test_skew();
    int n;
    n = nv0;
    send_frame(8'hAA, 0, 1'b0, 1'b1, 62);
    idle(1);
    checks++; if (cap0 !== 8'hAA) $display("FAIL skew_fast_data: got %h want aa", cap0); else passed++;
    send_frame(8'h55, 0, 1'b0, 1'b1, 66);
    repeat (2) @(negedge clk);
    checks++; if (cap0 !== 8'h55) $display("FAIL skew_slow_data: got %h want 55", cap0); else passed++;
    checks++; if (nv0 !== n + 2) $display("FAIL skew_count: got %0d want %0d", nv0, n + 2); else passed++;
    idle(1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_idle_lock();
    test_parity();
    test_framing();
    test_glitch();
    test_reset_mid_frame();
    test_skew();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
